mac_xw_streamer: RTL

Transmit side of the X/W byte-serial link into the neural-network MAC. On a start pulse it reads one full frame of X and W operand bytes from a dual-lane operand RAM and drives them onto the `x`/`w`/`data_en` bus. A frame is NUM_SLICES slices of BYTES_PER_SLICE bytes each. The byte and slice ordering matches the counters in the MAC receiver, so the receiver's byte and slice boundaries land exactly on this block's `slice_last`/`frame_last` markers.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_xw_streamer_if.sv | 26 ++
 rtl/mac_slice_byte_cnt.sv | 51 +++++
 rtl/mac_xw_streamer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Constants and types shared by the X/W streamer and the MAC receiver.
// Frame geometry must match on both ends of the byte-serial link.
package mac_pkg;

   localparam int BYTES_PER_SLICE = 6;
   localparam int NUM_SLICES      = 62;
   localparam int N               = BYTES_PER_SLICE * NUM_SLICES;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Counter width that stays legal for a modulus of 1.
   function automatic int cnt_w(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/mac_xw_streamer_if.sv
// Byte-serial X/W bus from the streamer (master) to the MAC receiver (slave).
interface mac_xw_streamer_if;

   logic [7:0] x;
   logic [7:0] w;
   logic       data_en;
   logic       slice_last;
   logic       frame_last;

   modport master (
      output x,
      output w,
      output data_en,
      output slice_last,
      output frame_last
   );

   modport slave (
      input x,
      input w,
      input data_en,
      input slice_last,
      input frame_last
   );

endinterface

// File: rtl/mac_slice_byte_cnt.sv
// Byte-within-slice and slice-within-frame counter pair; the last flags
// describe the position the counters currently hold.
module mac_slice_byte_cnt #(
   parameter int  BYTES_PER_SLICE = mac_pkg::BYTES_PER_SLICE,
   parameter int  NUM_SLICES      = mac_pkg::NUM_SLICES,
   localparam int BYTE_W          = mac_pkg::cnt_w(BYTES_PER_SLICE),
   localparam int SLICE_W         = mac_pkg::cnt_w(NUM_SLICES)
) (
   input  logic layer_clk,
   input  logic rst_n,
   input  logic clr,
   input  logic advance,
   output logic slice_last,
   output logic frame_last
);

   import mac_pkg::*;

   logic [BYTE_W-1:0]  byte_q, byte_d;
   logic [SLICE_W-1:0] slice_q, slice_d;

   assign slice_last = (byte_q == BYTE_W'(BYTES_PER_SLICE - 1));
   assign frame_last = slice_last && (slice_q == SLICE_W'(NUM_SLICES - 1));

   always_comb begin
      byte_d  = byte_q;
      slice_d = slice_q;
      if (clr) begin
         byte_d  = '0;
         slice_d = '0;
      end else if (advance) begin
         if (slice_last) begin
            byte_d  = '0;
            slice_d = frame_last ? '0 : slice_q + SLICE_W'(1);
         end else begin
            byte_d  = byte_q + BYTE_W'(1);
         end
      end
   end

   always_ff @(posedge layer_clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_q  <= '0;
         slice_q <= '0;
      end else begin
         byte_q  <= byte_d;
         slice_q <= slice_d;
      end
   end

endmodule

// File: rtl/mac_xw_streamer.sv
// Reads one frame of X/W operand bytes from the dual-lane RAM on start and
// streams them out with slice/frame boundary markers through a 2-stage pipe.
module mac_xw_streamer #(
   parameter int BYTES_PER_SLICE = mac_pkg::BYTES_PER_SLICE,
   parameter int NUM_SLICES      = mac_pkg::NUM_SLICES,
   parameter int ADDR_W          = 9
) (
   input  logic              layer_clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              hold,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_x,
   input  logic [7:0]        rd_w,
   output logic              busy,
   output logic              done,
   mac_xw_streamer_if.master xw
);

   import mac_pkg::*;

   localparam int                FRAME_WORDS = BYTES_PER_SLICE * NUM_SLICES;
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(FRAME_WORDS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
   logic              cnt_clr;
   logic              tag_slice_last, tag_frame_last;

   logic              s1_valid_q, s1_valid_d;
   logic              s1_slice_last_q, s1_slice_last_d;
   logic              s1_frame_last_q, s1_frame_last_d;

   logic              s2_valid_q, s2_valid_d;
   logic              s2_slice_last_q, s2_slice_last_d;
   logic              s2_frame_last_q, s2_frame_last_d;
   logic [7:0]        x_q, x_d;
   logic [7:0]        w_q, w_d;

   // Tags describe the word being read this cycle and advance with each read.
   mac_slice_byte_cnt #(
      .BYTES_PER_SLICE (BYTES_PER_SLICE),
      .NUM_SLICES      (NUM_SLICES)
   ) u_tag_cnt (
      .layer_clk  (layer_clk),
      .rst_n      (rst_n),
      .clr        (cnt_clr),
      .advance    (rd_en),
      .slice_last (tag_slice_last),
      .frame_last (tag_frame_last)
   );

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      rd_en      = 1'b0;
      cnt_clr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               word_cnt_d = '0;
               cnt_clr    = 1'b1;
            end
         end
         RUN: begin
            rd_en = !hold;
            if (rd_en) begin
               word_cnt_d = word_cnt_q + ADDR_W'(1);
               if (word_cnt_q == LAST_ADDR) begin
                  state_d    = DRAIN;
                  word_cnt_d = '0;
               end
            end
         end
         // Once stage 1 is empty the final byte is on the bus this cycle.
         DRAIN: begin
            if (!s1_valid_q) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      s1_valid_d      = rd_en;
      s1_slice_last_d = rd_en && tag_slice_last;
      s1_frame_last_d = rd_en && tag_frame_last;

      s2_valid_d      = s1_valid_q;
      s2_slice_last_d = s1_valid_q && s1_slice_last_q;
      s2_frame_last_d = s1_valid_q && s1_frame_last_q;
      x_d             = s1_valid_q ? rd_x : x_q;
      w_d             = s1_valid_q ? rd_w : w_q;
   end

   always_ff @(posedge layer_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         word_cnt_q      <= '0;
         s1_valid_q      <= 1'b0;
         s1_slice_last_q <= 1'b0;
         s1_frame_last_q <= 1'b0;
         s2_valid_q      <= 1'b0;
         s2_slice_last_q <= 1'b0;
         s2_frame_last_q <= 1'b0;
         x_q             <= '0;
         w_q             <= '0;
      end else begin
         state_q         <= state_d;
         word_cnt_q      <= word_cnt_d;
         s1_valid_q      <= s1_valid_d;
         s1_slice_last_q <= s1_slice_last_d;
         s1_frame_last_q <= s1_frame_last_d;
         s2_valid_q      <= s2_valid_d;
         s2_slice_last_q <= s2_slice_last_d;
         s2_frame_last_q <= s2_frame_last_d;
         x_q             <= x_d;
         w_q             <= w_d;
      end
   end

   assign rd_addr       = word_cnt_q;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);

   assign xw.x          = x_q;
   assign xw.w          = w_q;
   assign xw.data_en    = s2_valid_q;
   assign xw.slice_last = s2_slice_last_q;
   assign xw.frame_last = s2_frame_last_q;

endmodule
